// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shift unit.
// Operation codes and FSM states used by iter_shifter and shift_step.
package shifter_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts work_i by k_i (1..STEP) bits.
// Rotate datapath present only when SHIFTER_ROTR_EN is defined.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0] work_i,
    input  logic [1:0]       op_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        next_o = work_i >> k_i;
        unique case (op_i)
            OP_SLL:  next_o = work_i << k_i;
            OP_SRA:  next_o = $signed(work_i) >>> k_i;
`ifdef SHIFTER_ROTR_EN
            OP_ROTR: next_o = (work_i >> k_i)
                            | (work_i << (WIDTH - 32'(k_i)));
`endif
            default: next_o = work_i >> k_i;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA(/ROTR) unit, at most STEP bits per clock.
// Define SHIFTER_ROTR_EN to make op=11 a rotate right instead of SRL.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int KW = $clog2(STEP + 1);

    state_e           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   rem_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;

    logic [KW-1:0]    k_d;
    logic [SHW-1:0]   rem_d;
    logic [WIDTH-1:0] work_d;

    // k = min(rem, STEP); STEP < WIDTH so it always fits in SHW bits
    always_comb begin
        k_d   = (rem_q > SHW'(STEP)) ? KW'(STEP) : rem_q[KW-1:0];
        rem_d = rem_q - SHW'(k_d);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .work_i (work_q),
        .op_i   (op_q),
        .k_i    (k_d),
        .next_o (work_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            work_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
                        op_q   <= op;
                        work_q <= operand;
                        rem_q  <= shamt;
                        if (shamt == '0) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= operand;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= work_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
